// File: rtl/cim_pkg.sv
// Shared types and sizes for the CIM core scheduler and its readback port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cim_pkg;

    localparam int CORE_W    = 3;
    localparam int ROW_W     = 6;
    localparam int WROW_W    = 288;
    localparam int NUM_CORES = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        RUN     = 2'd2,
        SWAP    = 2'd3
    } state_t;

    // Advance a core pointer around the ring of cores
    function automatic logic [CORE_W-1:0] next_core(input logic [CORE_W-1:0] c);
        if (c == CORE_W'(NUM_CORES - 1)) begin
            return '0;
        end
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/cim_rd_port.sv
// Readback port: grants reads of non-computing cores and returns the row data.
// Latency: grant is combinational; rd_valid/rd_data one cycle after the grant.
// Backpressure: a weight load or a read of the computing core denies the grant; the requester holds rd_req.
module cim_rd_port
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [CORE_W-1:0] rd_core,
    input  logic              load_act,
    input  logic [CORE_W-1:0] cim_core,
    input  logic [WROW_W-1:0] weight_out,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [WROW_W-1:0] rd_data
);

    logic              rd_valid_q;
    logic [WROW_W-1:0] rd_data_q;

    // The computing core is never read, and a load beat owns the shared port
    assign rd_ack = rd_req && !load_act && (rd_core != cim_core);

    // Capture the addressed row one cycle after the grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_ack;
            if (rd_ack) begin
                rd_data_q <= weight_out;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/cim_core_scheduler.sv
// Ping-pong scheduler: loads the next tile into a standby core while the current core computes.
// Latency: load beats drive the CIM port in the accept cycle; psum_valid trails accepted beats by PSUM_LAT.
// Backpressure: wl_ready/act_ready drop when the tile load or compute is finished until the next swap.
module cim_core_scheduler
    import cim_pkg::*;
#(
    parameter int NUM_ROWS = 64,
    parameter int PSUM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_tiles,
    output logic              busy,
    output logic              done,
    input  logic              wl_valid,
    output logic              wl_ready,
    input  logic [WROW_W-1:0] wl_data,
    input  logic              act_valid,
    input  logic              act_last,
    output logic              act_ready,
    output logic              psum_valid,
    input  logic              rd_req,
    input  logic [CORE_W-1:0] rd_core,
    input  logic [ROW_W-1:0]  rd_row,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [WROW_W-1:0] rd_data,
    output logic [CORE_W-1:0] CIM_Core_A,
    output logic [CORE_W-1:0] STD_Core_A,
    output logic              STDW,
    output logic              STDR,
    output logic [ROW_W-1:0]  STD_row_A,
    output logic [WROW_W-1:0] weight_in,
    input  logic [WROW_W-1:0] weight_out
);

    state_t              state_q;
    logic [CORE_W-1:0]   cim_ptr_q;
    logic [CORE_W-1:0]   std_ptr_q;
    logic [7:0]          ntiles_q;
    logic [7:0]          tiles_loaded_q;
    logic [7:0]          tiles_computed_q;
    logic [ROW_W-1:0]    load_row_q;
    logic                load_done_q;
    logic                comp_done_q;
    logic                done_q;
    logic [PSUM_LAT-1:0] psum_sr_q;

    logic load_fire;
    logic act_fire;
    logic last_row;
    logic run_exit;

    // A tile load is open during PRELOAD, or during RUN while tiles remain to be loaded
    assign wl_ready  = ((state_q == PRELOAD) ||
                        ((state_q == RUN) && (tiles_loaded_q < ntiles_q))) && !load_done_q;
    assign load_fire = wl_valid && wl_ready;
    assign act_ready = (state_q == RUN) && !comp_done_q;
    assign act_fire  = act_valid && act_ready;
    assign last_row  = (load_row_q == ROW_W'(NUM_ROWS - 1));
    // Leave RUN once compute is done and the standby core is ready (or nothing left to load)
    assign run_exit  = (state_q == RUN) && comp_done_q &&
                       (load_done_q || (tiles_loaded_q == ntiles_q));

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign CIM_Core_A = cim_ptr_q;
    assign psum_valid = psum_sr_q[PSUM_LAT-1];

    // Job FSM with tile counters, load row counter and the two core pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cim_ptr_q        <= '0;
            std_ptr_q        <= CORE_W'(1);
            ntiles_q         <= '0;
            tiles_loaded_q   <= '0;
            tiles_computed_q <= '0;
            load_row_q       <= '0;
            load_done_q      <= 1'b0;
            comp_done_q      <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_fire) begin
                if (last_row) begin
                    load_row_q     <= '0;
                    tiles_loaded_q <= tiles_loaded_q + 8'd1;
                    load_done_q    <= 1'b1;
                end else begin
                    load_row_q <= load_row_q + 1'b1;
                end
            end
            if (act_fire && act_last) begin
                tiles_computed_q <= tiles_computed_q + 8'd1;
                comp_done_q      <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start && (num_tiles != 8'd0)) begin
                        ntiles_q         <= num_tiles;
                        cim_ptr_q        <= '0;
                        std_ptr_q        <= CORE_W'(1);
                        tiles_loaded_q   <= '0;
                        tiles_computed_q <= '0;
                        load_row_q       <= '0;
                        load_done_q      <= 1'b0;
                        comp_done_q      <= 1'b0;
                        state_q          <= PRELOAD;
                    end
                end
                PRELOAD: begin
                    if (load_done_q) begin
                        state_q <= SWAP;
                    end
                end
                SWAP: begin
                    cim_ptr_q   <= next_core(cim_ptr_q);
                    std_ptr_q   <= next_core(std_ptr_q);
                    load_done_q <= 1'b0;
                    comp_done_q <= 1'b0;
                    state_q     <= RUN;
                end
                RUN: begin
                    if (run_exit) begin
                        if (tiles_computed_q == ntiles_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SWAP;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Accepted-beat strobe delayed PSUM_LAT cycles to mark partial sums valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psum_sr_q <= '0;
        end else begin
            psum_sr_q[0] <= act_fire;
            for (int i = 1; i < PSUM_LAT; i++) begin
                psum_sr_q[i] <= psum_sr_q[i-1];
            end
        end
    end

    // Standby-core port mux: load beat first, then a granted read, else park on the standby core
    always_comb begin
        STDW       = 1'b0;
        STD_Core_A = std_ptr_q;
        STD_row_A  = '0;
        weight_in  = '0;
        if (load_fire) begin
            STDW       = 1'b1;
            STD_Core_A = std_ptr_q;
            STD_row_A  = load_row_q;
            weight_in  = wl_data;
        end else if (rd_ack) begin
            STD_Core_A = rd_core;
            STD_row_A  = rd_row;
        end
    end

    assign STDR = rd_ack;

    cim_rd_port u_rd_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .rd_core    (rd_core),
        .load_act   (load_fire),
        .cim_core   (cim_ptr_q),
        .weight_out (weight_out),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

endmodule
